// File: rtl/servo_pkg.sv
// Shared servo-path definitions.
//   SIG_W    : actuator / error / gain word width
//   PROD_W   : full product width of two SIG_W operands
//   PTERM_W  : proportional term width after scaling
//   ITERM_W  : integrator contribution width entering the output sum
//   SUM_W    : width of the PI + relock sum before clamping
//   RAIL_LO / RAIL_HI : bit positions inside railed[1:0]
//   sat_s()  : signed saturation of a 64-bit value to 'width' bits
package servo_pkg;
  localparam int SIG_W   = 16;
  localparam int PROD_W  = 32;
  localparam int PTERM_W = 17;
  // 19 bits is wide enough that a saturated integrator term still rails
  // the output for any legal P term / relock offset, and the sum of
  // 19 + 17 + 16 bit terms cannot overflow SUM_W.
  localparam int ITERM_W = 19;
  localparam int SUM_W   = 20;
  localparam int RAIL_LO = 0;
  localparam int RAIL_HI = 1;

  function automatic logic signed [63:0] sat_s(input logic signed [63:0] value,
                                               input int width);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction
endpackage

// File: rtl/relock_loop_filter_if.sv
// Servo channel bus between the relock controller / demodulator side
// (master) and the loop filter (slave).
//   on_in, error_in, kp_in, ki_in, minval_in, maxval_in,
//   hold_in, clear_in, relock_in   : master -> filter
//   signal_out, railed_out         : filter -> master
interface relock_loop_filter_if;
  import servo_pkg::*;
  logic                    on_in;
  logic signed [SIG_W-1:0] error_in;
  logic signed [SIG_W-1:0] kp_in;
  logic signed [SIG_W-1:0] ki_in;
  logic signed [SIG_W-1:0] minval_in;
  logic signed [SIG_W-1:0] maxval_in;
  logic                    hold_in;
  logic                    clear_in;
  logic signed [SIG_W-1:0] relock_in;
  logic signed [SIG_W-1:0] signal_out;
  logic [1:0]              railed_out;

  modport master (
    output on_in, error_in, kp_in, ki_in, minval_in, maxval_in,
           hold_in, clear_in, relock_in,
    input  signal_out, railed_out
  );

  modport slave (
    input  on_in, error_in, kp_in, ki_in, minval_in, maxval_in,
           hold_in, clear_in, relock_in,
    output signal_out, railed_out
  );
endinterface

// File: rtl/sat_clamp.sv
// Combinational signed clamp of a SUM_W value into a SIG_W word.
//   value_in   : signed SUM_W input
//   min_in     : signed lower limit
//   max_in     : signed upper limit
//   value_out  : clamped SIG_W result
//   railed_out : [1] max clamp fired, [0] min clamp fired
// The max clamp is evaluated first and the min clamp second, so with
// min_in > max_in the result is always min_in and only bit [0] is set.
module sat_clamp
  import servo_pkg::*;
(
  input  logic signed [SUM_W-1:0] value_in,
  input  logic signed [SIG_W-1:0] min_in,
  input  logic signed [SIG_W-1:0] max_in,
  output logic signed [SIG_W-1:0] value_out,
  output logic [1:0]              railed_out
);
  logic signed [SUM_W-1:0] v;

  always_comb begin
    v          = value_in;
    railed_out = 2'b00;
    if (v > SUM_W'(max_in)) begin
      v          = SUM_W'(max_in);
      railed_out = 2'b10;
    end
    if (v < SUM_W'(min_in)) begin
      v          = SUM_W'(min_in);
      railed_out = 2'b01;
    end
    value_out = v[SIG_W-1:0];
  end
endmodule

// File: rtl/relock_loop_filter.sv
// Pipelined PI servo loop filter, one per servo channel.
//   clk_in   : clock
//   rst_n_in : synchronous active-low reset
//   bus      : servo channel bus (slave side), see relock_loop_filter_if
// Three-stage pipe, one sample per cycle:
//   S1 products + hold/clear alignment, S2 integrator / P term / relock
//   offset, S3 sum, clamp and rail report.
// Integrator anti-windup uses the registered rail status, so it reacts
// one cycle late; the integrator can overshoot the rail by one step.
module relock_loop_filter
  import servo_pkg::*;
#(
  parameter int KP_SHIFT = 8,
  parameter int KI_SHIFT = 24,
  parameter int ACC_W    = 48   // must stay <= 63 for sat_s
) (
  input logic clk_in,
  input logic rst_n_in,
  relock_loop_filter_if.slave bus
);
  // S1
  logic signed [PROD_W-1:0]  p_prod, i_prod;
  logic                      hold1, clear1;
  // S2
  logic signed [ACC_W-1:0]   integ;
  logic signed [PTERM_W-1:0] p_term;
  logic signed [SIG_W-1:0]   relock2;
  // combinational
  logic signed [ACC_W-1:0]   integ_nxt;
  logic signed [PTERM_W-1:0] p_term_nxt;
  logic signed [ITERM_W-1:0] i_term;
  logic signed [SUM_W-1:0]   sum;
  logic signed [SIG_W-1:0]   clamp_val;
  logic [1:0]                clamp_rail;
  logic                      windup;

  always_comb begin
    // Stop integrating further into a rail that is already hit.
    windup = (bus.railed_out[RAIL_HI] && (i_prod > 0)) ||
             (bus.railed_out[RAIL_LO] && (i_prod < 0));
    integ_nxt  = ACC_W'(sat_s(64'(integ) + 64'(i_prod), ACC_W));
    p_term_nxt = hold1 ? '0 : PTERM_W'(sat_s(64'(p_prod >>> KP_SHIFT), PTERM_W));
    i_term     = ITERM_W'(sat_s(64'(integ >>> KI_SHIFT), ITERM_W));
    sum        = SUM_W'(i_term) + SUM_W'(p_term) + SUM_W'(relock2);
  end

  sat_clamp u_clamp (
    .value_in  (sum),
    .min_in    (bus.minval_in),
    .max_in    (bus.maxval_in),
    .value_out (clamp_val),
    .railed_out(clamp_rail)
  );

  always_ff @(posedge clk_in) begin
    if (!rst_n_in || !bus.on_in) begin
      p_prod         <= '0;
      i_prod         <= '0;
      hold1          <= 1'b0;
      clear1         <= 1'b0;
      integ          <= '0;
      p_term         <= '0;
      relock2        <= '0;
      bus.signal_out <= '0;
      bus.railed_out <= '0;
    end else begin
      p_prod  <= PROD_W'(bus.error_in) * PROD_W'(bus.kp_in);
      i_prod  <= PROD_W'(bus.error_in) * PROD_W'(bus.ki_in);
      hold1   <= bus.hold_in;
      clear1  <= bus.clear_in;

      if (clear1)                 integ <= '0;
      else if (!hold1 && !windup) integ <= integ_nxt;
      p_term  <= p_term_nxt;
      relock2 <= bus.relock_in;

      bus.signal_out <= clamp_val;
      bus.railed_out <= clamp_rail;
    end
  end
endmodule

// File: tb/tb_relock_loop_filter.sv
module tb_relock_loop_filter;
  localparam int KP = 8;
  localparam int KI = 0;

  logic clk_in = 1'b0;
  logic rst_n_in;
  int   n_chk = 0;
  int   n_fail = 0;

  relock_loop_filter_if bus();

  relock_loop_filter #(.KP_SHIFT(KP), .KI_SHIFT(KI), .ACC_W(48)) dut (
    .clk_in  (clk_in),
    .rst_n_in(rst_n_in),
    .bus     (bus)
  );

  always #5 clk_in = ~clk_in;

  // Reference model: input snapshots of the previous two edges plus the
  // integrator and rail state. Output at edge t is
  //   clamp(integ + P(sample t-2) + relock(sample t-1), clamps(sample t)).
  typedef struct {
    longint err, kp, ki, rel;
    bit     hold, clear;
  } snap_t;
  localparam snap_t ZERO = '{0, 0, 0, 0, 1'b0, 1'b0};

  snap_t  h1, h2;
  longint m_integ;
  longint m_out;
  int     m_rail;

  task automatic model_edge();
    snap_t  cur;
    longint p, sum, o, ip, mn, mx, lim;
    int     r;
    cur.err = bus.error_in;  cur.kp = bus.kp_in;  cur.ki = bus.ki_in;
    cur.rel = bus.relock_in; cur.hold = bus.hold_in; cur.clear = bus.clear_in;
    if (!rst_n_in || !bus.on_in) begin
      m_integ = 0; m_out = 0; m_rail = 0; h1 = ZERO; h2 = ZERO;
      return;
    end
    p = (h2.err * h2.kp) >>> KP;
    if (p > 65535)  p = 65535;
    if (p < -65536) p = -65536;
    if (h2.hold)    p = 0;
    sum = (m_integ >>> KI) + p + h1.rel;
    mx = bus.maxval_in; mn = bus.minval_in;
    o = sum; r = 0;
    if (o > mx) begin o = mx; r = 2; end
    if (o < mn) begin o = mn; r = 1; end
    ip = h1.err * h1.ki;
    if (h1.clear) m_integ = 0;
    else if (!h1.hold && !((m_rail == 2 && ip > 0) || (m_rail == 1 && ip < 0))) begin
      lim = 64'sd1 <<< 47;
      m_integ = m_integ + ip;
      if (m_integ > lim - 1) m_integ = lim - 1;
      if (m_integ < -lim)    m_integ = -lim;
    end
    m_out = o; m_rail = r; h2 = h1; h1 = cur;
  endtask

  // One clock edge: advance model, clock, then compare against model.
  task automatic step();
    model_edge();
    @(posedge clk_in);
    #1;
    n_chk += 2;
    assert (bus.signal_out === 16'(m_out)) else begin
      n_fail++;
      $error("FAIL model_sig t=%0t got %0d expected %0d", $time, bus.signal_out, m_out);
    end
    assert (bus.railed_out === 2'(m_rail)) else begin
      n_fail++;
      $error("FAIL model_rail t=%0t got %0b expected %0b", $time, bus.railed_out, 2'(m_rail));
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic flush();  // on_in low for one edge clears everything
    bus.on_in = 1'b0; step(); bus.on_in = 1'b1;
  endtask

  initial begin
    int  left;
    bit  left_rail;
    logic signed [15:0] a, b;
    rst_n_in = 1'b0;
    bus.on_in = 1'b1;   bus.error_in = 16'sd1000; bus.kp_in = 16'sd100;
    bus.ki_in = 16'sd100; bus.minval_in = -16'sd32767; bus.maxval_in = 16'sd32767;
    bus.hold_in = 1'b0; bus.clear_in = 1'b0; bus.relock_in = '0;
    steps(2);
    chk("reset_sig", int'(bus.signal_out), 0);
    chk("reset_rail", int'(bus.railed_out), 0);

    // 1: reset / off mid-stream
    rst_n_in = 1'b1;
    steps(5);
    rst_n_in = 1'b0; step(); rst_n_in = 1'b1;
    chk("rst_mid_sig", int'(bus.signal_out), 0);
    chk("rst_mid_rail", int'(bus.railed_out), 0);
    steps(2);
    chk("rst_lat2_sig", int'(bus.signal_out), 0);
    step();
    chk("rst_lat3_sig", int'(bus.signal_out), 32767);
    chk("rst_lat3_rail", int'(bus.railed_out), 2);
    steps(3);
    flush();
    chk("off_sig", int'(bus.signal_out), 0);
    chk("off_rail", int'(bus.railed_out), 0);
    steps(2);
    chk("off_lat2_sig", int'(bus.signal_out), 0);
    step();
    chk("off_lat3_sig", int'(bus.signal_out), 32767);

    // 2: P only
    flush();
    bus.ki_in = 0; bus.kp_in = 16'sd256; bus.error_in = 16'sd1234;
    steps(2);
    chk("p_lat2", int'(bus.signal_out), 0);
    step();
    chk("p_lat3", int'(bus.signal_out), 1234);
    chk("p_rail", int'(bus.railed_out), 0);

    // 3: integrator ramp
    flush();
    bus.kp_in = 0; bus.ki_in = 16'sd1; bus.error_in = 16'sd1;
    steps(2);
    for (int k = 3; k <= 10; k++) begin
      step();
      chk($sformatf("ramp_%0d", k), int'(bus.signal_out), k - 2);
    end

    // 4: anti-windup at maxval=100
    bus.maxval_in = 16'sd100;
    steps(120);
    chk("aw_sig", int'(bus.signal_out), 100);
    chk("aw_rail", int'(bus.railed_out), 2);
    bus.error_in = -16'sd1;
    left = 0; left_rail = 1'b0;
    for (int i = 1; i <= 4 && !left_rail; i++) begin
      step();
      if (bus.railed_out == 2'b00) begin left_rail = 1'b1; left = i; end
    end
    chk("aw_leave", int'(left_rail), 1);
    bus.maxval_in = 16'sd32767;

    // 5: hold / clear
    flush();
    bus.kp_in = 16'sd1000; bus.ki_in = 16'sd100; bus.error_in = 16'sd5;
    step();
    bus.hold_in = 1'b1;
    steps(5);
    chk("hold_500", int'(bus.signal_out), 500);
    bus.relock_in = 16'sd300;
    steps(3);
    chk("hold_800", int'(bus.signal_out), 800);
    bus.clear_in = 1'b1; step(); bus.clear_in = 1'b0;
    steps(2);
    chk("clear_out", int'(bus.signal_out), 300);
    bus.hold_in = 1'b0;
    steps(4);
    bus.hold_in = 1'b1; bus.clear_in = 1'b1; step(); bus.clear_in = 1'b0;
    steps(3);
    chk("clear_hold_out", int'(bus.signal_out), 300);
    bus.hold_in = 1'b0; bus.relock_in = '0;

    // 6: clamp edge cases
    flush();
    bus.kp_in = 0; bus.ki_in = 0; bus.error_in = 0;
    bus.minval_in = 16'sd50; bus.maxval_in = 16'sd10;
    steps(2);
    chk("inv_sig", int'(bus.signal_out), 50);
    chk("inv_rail", int'(bus.railed_out), 1);
    bus.minval_in = -16'sd32768; bus.maxval_in = 16'sd32767;
    bus.kp_in = -16'sd32768; bus.error_in = 16'sd256; bus.relock_in = -16'sd32768;
    steps(4);
    chk("neg_sig", int'(bus.signal_out), -32768);
    chk("neg_rail", int'(bus.railed_out), 1);

    // Randomized phase, checked against the model every cycle
    flush();
    for (int i = 0; i < 400; i++) begin
      bus.error_in = 16'($urandom);
      bus.kp_in    = 16'($urandom);
      bus.ki_in    = 16'($signed($urandom_range(0, 128)) - 64);
      bus.relock_in = 16'($urandom);
      a = 16'($urandom); b = 16'($urandom);
      if ($urandom_range(0, 3) != 0 && a > b) begin
        bus.minval_in = b; bus.maxval_in = a;
      end else begin
        bus.minval_in = a; bus.maxval_in = b;
      end
      bus.hold_in  = ($urandom_range(0, 9) == 0);
      bus.clear_in = ($urandom_range(0, 19) == 0);
      bus.on_in    = ($urandom_range(0, 99) != 0);
      rst_n_in     = ($urandom_range(0, 99) != 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
